// File: rtl/csa_pkg.sv
// csa_pkg: shared widths, FSM state type and the 3:2 carry-save helper
package csa_pkg;
    localparam int CSA_W     = 20;
    localparam int CSA_LANES = 7;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    typedef logic [CSA_W-1:0] word_t;
    typedef struct packed {
        word_t s;
        word_t c;
    } csa_t;

    // One 3:2 compressor row; the carry is pre-shifted and bit 19's carry is dropped
    function automatic csa_t csa3(word_t a, word_t b, word_t d);
        csa_t r;
        r.s = a ^ b ^ d;
        r.c = ((a & b) | (a & d) | (b & d)) << 1;
        return r;
    endfunction
endpackage

// File: rtl/csa_accum_ctrl_if.sv
// csa_accum_ctrl_if: input beat stream, redundant result stream and status
interface csa_accum_ctrl_if
    import csa_pkg::*;
#(
    parameter int TERM_CNT_W = 8
);
    logic                             in_valid;
    logic                             in_ready;
    logic [CSA_LANES-1:0][CSA_W-1:0]  in_data;
    logic [2:0]                       in_cnt;
    logic                             in_last;
    logic                             out_valid;
    logic                             out_ready;
    logic [CSA_W-1:0]                 out_c;
    logic [CSA_W-1:0]                 out_s;
    logic [TERM_CNT_W-1:0]            out_terms;
    logic                             busy;

    modport master (
        output in_valid, in_data, in_cnt, in_last, out_ready,
        input  in_ready, out_valid, out_c, out_s, out_terms, busy
    );
    modport slave (
        input  in_valid, in_data, in_cnt, in_last, out_ready,
        output in_ready, out_valid, out_c, out_s, out_terms, busy
    );
endinterface

// File: rtl/csa_accum_ctrl_add_16_9.sv
// add_16_9: 9:2 carry-save compressor tree built from four rows of 3:2 cells
module add_16_9
    import csa_pkg::*;
(
    input  word_t [8:0] ops,
    output word_t       c,
    output word_t       s
);
    csa_t l1a, l1b, l1c, l2a, l2b, l3, l4;

    // 9 -> 6 -> 4 -> 3 -> 2 reduction
    always_comb begin
        l1a = csa3(ops[0], ops[1], ops[2]);
        l1b = csa3(ops[3], ops[4], ops[5]);
        l1c = csa3(ops[6], ops[7], ops[8]);
        l2a = csa3(l1a.s, l1a.c, l1b.s);
        l2b = csa3(l1b.c, l1c.s, l1c.c);
        l3  = csa3(l2a.s, l2a.c, l2b.s);
        l4  = csa3(l3.s, l3.c, l2b.c);
        c   = l4.c;
        s   = l4.s;
    end
endmodule

// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: packet accumulator keeping a redundant (carry, sum) total of masked lanes
module csa_accum_ctrl
    import csa_pkg::*;
#(
    parameter int TERM_CNT_W = 8
) (
    input logic              clk,
    input logic              reset,
    csa_accum_ctrl_if.slave  bus
);
    state_t                          state;
    word_t                           acc_c, acc_s, tree_c, tree_s;
    logic [CSA_LANES-1:0][CSA_W-1:0] lanes;
    logic [TERM_CNT_W-1:0]           terms;
    logic [TERM_CNT_W:0]             terms_sum;
    logic [TERM_CNT_W-1:0]           terms_next;
    logic                            accept;

    assign accept     = bus.in_valid && bus.in_ready;
    assign terms_sum  = {1'b0, terms} + (TERM_CNT_W+1)'(bus.in_cnt);
    assign terms_next = terms_sum[TERM_CNT_W] ? '1 : terms_sum[TERM_CNT_W-1:0];

    // Zero every lane at or above in_cnt so it contributes nothing
    always_comb begin
        for (int i = 0; i < CSA_LANES; i++)
            lanes[i] = (3'(i) < bus.in_cnt) ? bus.in_data[i] : '0;
    end

    add_16_9 u_tree (
        .ops ({acc_c, acc_s, lanes}),
        .c   (tree_c),
        .s   (tree_s)
    );

    assign bus.out_c     = acc_c;
    assign bus.out_s     = acc_s;
    assign bus.out_terms = terms;

    // Packet FSM; handshake flags are registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            acc_c         <= '0;
            acc_s         <= '0;
            terms         <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b1;
        end else if (state == DONE) begin
            if (bus.out_ready) begin
                state         <= IDLE;
                acc_c         <= '0;
                acc_s         <= '0;
                terms         <= '0;
                bus.out_valid <= 1'b0;
                bus.busy      <= 1'b0;
                bus.in_ready  <= 1'b1;
            end
        end else if (accept) begin
            state         <= bus.in_last ? DONE : ACCUM;
            acc_c         <= tree_c;
            acc_s         <= tree_s;
            terms         <= terms_next;
            bus.out_valid <= bus.in_last;
            bus.busy      <= 1'b1;
            bus.in_ready  <= !bus.in_last;
        end
    end
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// tb_csa_accum_ctrl: random and directed packets checked against an arithmetic sum model
module tb_csa_accum_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [6:0][19:0] bd [64];
    logic [2:0]       bc [64];
    int   exp_sum;
    int   exp_terms;

    always #5 clk = ~clk;

    csa_accum_ctrl_if #(.TERM_CNT_W(8)) bus ();

    csa_accum_ctrl #(.TERM_CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int beat_sum(input logic [6:0][19:0] d, input logic [2:0] c);
        int s = 0;
        for (int i = 0; i < int'(c); i++) s += int'(d[i]);
        return s;
    endfunction

    task automatic idle_in();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_cnt   = '0;
        bus.in_data  = '0;
    endtask

    task automatic check_result(input string tag);
        logic [19:0] r;
        r = bus.out_c + bus.out_s;
        check({tag, ".valid"}, 32'(bus.out_valid), 1);
        check({tag, ".in_ready"}, 32'(bus.in_ready), 0);
        check({tag, ".busy"}, 32'(bus.busy), 1);
        check({tag, ".sum"}, 32'(r), exp_sum);
        check({tag, ".terms"}, 32'(bus.out_terms), exp_terms);
    endtask

    // Offer nb beats from bd/bc, then hold the result for `hold` cycles before taking it
    task automatic send(input string tag, input int nb, input int hold, input bit gaps);
        exp_sum   = 0;
        exp_terms = 0;
        for (int b = 0; b < nb; b++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                idle_in();
                @(negedge clk);
            end
            check({tag, ".rdy"}, 32'(bus.in_ready), 1);
            bus.in_valid = 1'b1;
            bus.in_data  = bd[b];
            bus.in_cnt   = bc[b];
            bus.in_last  = (b == nb - 1);
            exp_sum   = (exp_sum + beat_sum(bd[b], bc[b])) % (1 << 20);
            exp_terms = (exp_terms + int'(bc[b]) > 255) ? 255 : exp_terms + int'(bc[b]);
            @(negedge clk);
            if (b < nb - 1) check({tag, ".busy_mid"}, 32'(bus.busy), 1);
        end
        bus.in_valid = 1'b1;
        for (int i = 0; i < 7; i++) bus.in_data[i] = 20'($urandom);
        bus.in_cnt  = 3'd7;
        bus.in_last = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            check_result(tag);
            if (h < hold) @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        idle_in();
        check({tag, ".idle_valid"}, 32'(bus.out_valid), 0);
        check({tag, ".idle_busy"}, 32'(bus.busy), 0);
        check({tag, ".idle_rdy"}, 32'(bus.in_ready), 1);
    endtask

    initial begin
        reset = 1'b1;
        bus.out_ready = 1'b0;
        idle_in();
        repeat (3) @(negedge clk);
        check("rst.valid", 32'(bus.out_valid), 0);
        check("rst.busy", 32'(bus.busy), 0);
        check("rst.rdy", 32'(bus.in_ready), 1);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) bd[0][i] = 20'(i + 1);
        bc[0] = 3'd7;
        send("single", 1, 0, 0);
        check("single.lit", exp_sum, 28);

        bd[0] = '1;
        bc[0] = 3'd3;
        send("mask", 1, 0, 0);
        check("mask.lit", exp_sum, 32'hFFFFD);

        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 7; i++) bd[b][i] = 20'h10000;
            bc[b] = 3'd7;
        end
        send("wrap", 3, 5, 0);
        check("wrap.lit", exp_sum, 32'h50000);

        for (int i = 0; i < 7; i++) bd[0][i] = 20'(100 * (i + 1));
        bc[0] = 3'd2;
        bd[1] = '1;
        bc[1] = 3'd0;
        bc[2] = 3'd1;
        bd[2] = bd[0];
        send("cnt0", 3, 1, 0);

        for (int b = 0; b < 40; b++) begin
            for (int i = 0; i < 7; i++) bd[b][i] = 20'($urandom);
            bc[b] = 3'd7;
        end
        send("sat", 40, 0, 0);
        check("sat.lit", exp_terms, 255);

        for (int b = 0; b < 2; b++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = bd[b];
            bus.in_cnt   = 3'd7;
            bus.in_last  = 1'b0;
            @(negedge clk);
        end
        reset = 1'b1;
        idle_in();
        repeat (2) begin
            @(negedge clk);
            check("abort.valid", 32'(bus.out_valid), 0);
            check("abort.busy", 32'(bus.busy), 0);
            check("abort.rdy", 32'(bus.in_ready), 1);
        end
        reset = 1'b0;
        @(negedge clk);
        bd[0] = '0;
        bd[0][0] = 20'd5;
        bc[0] = 3'd1;
        send("after_rst", 1, 0, 0);
        check("after_rst.lit", exp_sum, 5);

        for (int p = 0; p < 30; p++) begin
            int nb;
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                for (int i = 0; i < 7; i++) bd[b][i] = 20'($urandom);
                bc[b] = 3'($urandom_range(0, 7));
            end
            send("rand", nb, $urandom_range(0, 3), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/csa_accum_ctrl.md
CSA_ACCUM_CTRL -- requirements
Module: csa_accum_ctrl

Interface
REQ-001 Parameter TERM_CNT_W, default 8, SHALL set the width of the accepted-term counter.
REQ-002 Port clk, input, 1: SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1: SHALL be an asynchronous, active-high reset.
REQ-004 Port in_valid, input, 1: SHALL mean an input beat is offered.
REQ-005 Port in_ready, output, 1: SHALL mean the block accepts a beat this cycle.
REQ-006 Port in_data, input, [6:0][19:0]: SHALL carry seven 20-bit operand lanes.
REQ-007 Port in_cnt, input, 3: SHALL give the number of valid lanes, starting at lane 0.
REQ-008 Port in_last, input, 1: SHALL mark the final beat of a packet.
REQ-009 Port out_valid, output, 1: SHALL mean a redundant result is presented.
REQ-010 Port out_ready, input, 1: SHALL mean the consumer takes the result.
REQ-011 Port out_c, output, 20: SHALL be the carry word, already aligned, so that the result is out_c+out_s mod 2^20.
REQ-012 Port out_s, output, 20: SHALL be the sum word.
REQ-013 Port out_terms, output, TERM_CNT_W: SHALL be the number of lanes accepted in the packet, saturating.
REQ-014 Port busy, output, 1: SHALL be high in the ACCUM and DONE states.

Function
REQ-015 The block SHALL have three states: IDLE, ACCUM and DONE.
REQ-016 The block SHALL assert in_ready exactly when the state is not DONE.
REQ-017 A beat SHALL be accepted on a cycle where in_valid and in_ready are both high.
REQ-018 On each accepted beat, the 9:2 tree inputs SHALL be the seven masked lanes plus acc_c plus acc_s.
REQ-019 The tree outputs SHALL be registered into acc_c and acc_s in the same cycle as the accept.
REQ-020 Lanes with index >= in_cnt SHALL be forced to zero before entering the tree.
REQ-021 An in_cnt of 0 SHALL leave the accumulator sum unchanged while still accepting the beat.
REQ-022 All arithmetic SHALL be modulo 2^20; carry bits shifted out of bit 19 SHALL be discarded.
REQ-023 State transitions SHALL be as follows:
- IDLE to ACCUM on an accept with in_last low.
- IDLE or ACCUM to DONE on an accept with in_last high.
- ACCUM to ACCUM on an accept with in_last low.
- DONE to IDLE on out_valid & out_ready.
REQ-024 The block SHALL assert out_valid exactly in DONE, which is one cycle after the in_last accept (latency 1).
REQ-025 While in DONE, out_c, out_s and out_terms SHALL hold stable until the handshake completes.
REQ-026 On the DONE handshake, acc_c, acc_s and the term counter SHALL clear to 0 in the same edge as the transition to IDLE.
REQ-027 The term counter SHALL add in_cnt on each accept and SHALL saturate at 2^TERM_CNT_W-1.
REQ-028 The block SHALL NOT accept a beat in the same cycle that DONE completes; the next packet starts no earlier than the cycle after.
REQ-029 A single-beat packet (in_last on the first beat) SHALL be legal.

Reset
REQ-030 While reset is high, the block SHALL force state IDLE, acc_c=0, acc_s=0, term counter=0, out_valid=0 and busy=0; in_ready SHALL be 1.
REQ-031 Assertion of reset mid-packet or in DONE SHALL discard the partial result, with no output handshake.
REQ-032 The first accept after reset deassertion SHALL start a fresh packet.

Structure
REQ-033 A shared package csa_pkg SHALL hold CSA_W=20, CSA_LANES=7 and the state enum.
REQ-034 The block SHALL instantiate exactly one add_16_9 as its sole sub-module.
REQ-035 The block SHALL place no combinational path from in_valid to out_valid.

Verification
REQ-036 Single beat: lanes 0..6 = 1..7, in_cnt=7, in_last=1 -> next cycle out_valid=1, out_c+out_s=28, out_terms=7.
REQ-037 Masking: all lanes 0xFFFFF, in_cnt=3, last -> sum 0xFFFFD mod 2^20, out_terms=3.
REQ-038 Multi-beat wrap: 3 beats of seven 0x10000 lanes, in_cnt=7, last on beat 3 -> sum 0x50000, out_terms=21.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles in DONE -> in_ready=0 and outputs stable throughout; handshake -> IDLE, next packet result unaffected by the previous one.
REQ-040 Saturation and reset: 40 beats with in_cnt=7 -> out_terms=255; separately, assert reset after beat 2 of 3 -> out_valid stays 0, and the next one-beat packet of value 5 gives sum 5.
